branch_history_tracker: RTL and testbench
=========================================

# branch_history_tracker

Parametrised global-history manager for the branch predictor front end. It keeps the speculative global branch history and checkpoints it per fetch ID. It shifts in up to MAX_BR conditional-branch outcomes per fetch bundle and rebuilds the history in one cycle after a mispredict. It also serves a registered history read port for the predictor-update path and applies back-pressure when the checkpoint file is full.

## Interface
Parameters:
- HIST_LEN, 16, global history length in bits
- FETCH_ID_W, 3, fetch-ID width; checkpoint depth DEPTH = 2**FETCH_ID_W
- MAX_BR, 2, predicted branch slots per fetch bundle
- OFFS_W, 3, width of a branch offset within a bundle

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- IN_fetchValid  in  1  fetch bundle accepted this cycle
- IN_fetchID  in  FETCH_ID_W  ID of that bundle
- IN_brValid  in  MAX_BR  slot holds a predicted conditional branch
- IN_brOffs  in  MAX_BR x OFFS_W  slot offset; valid slots are strictly ascending
- IN_brTaken  in  MAX_BR  predicted direction per slot
- OUT_history  out  HIST_LEN  lookup history for the current fetch
- OUT_stall  out  1  checkpoint file full; fetch must not assert IN_fetchValid
- IN_comValid  in  1  oldest live bundle committed
- IN_mispr  in  1  mispredict
- IN_misprFetchID  in  FETCH_ID_W  mispredicted bundle
- IN_misprOffs  in  OFFS_W  offset of the mispredicting instruction
- IN_misprHistAct  in  2  HIST_NONE / HIST_WRITE_0 / HIST_WRITE_1 / HIST_APPEND_1
- IN_updValid  in  1  history read request
- IN_updFetchID  in  FETCH_ID_W  ID to read
- OUT_updValid  out  1  read data valid
- OUT_updHistory  out  HIST_LEN  checkpointed history of IN_updFetchID

## Operation
- State:
  - history register H (HIST_LEN)
  - checkpoint RAM of DEPTH entries, each {history, brValid, brOffs, brTaken}
  - live counter CNT (0..DEPTH) and commit pointer COM (FETCH_ID_W)
  - one-stage recovery register REC {valid, fetchID, offs, histAct}
- Lookup:
  - OUT_history = H; while REC.valid, OUT_history = recovered history R (combinational bypass).
- Fetch:
  - On IN_fetchValid && !IN_mispr: write {OUT_history, IN_br*} to the checkpoint entry at IN_fetchID.
  - H <= OUT_history shifted left once per valid slot in ascending offset order, inserting IN_brTaken; slots after the first taken slot are ignored. CNT++.
- Commit:
  - On IN_comValid: COM++ and CNT--. Commit with CNT==0 is illegal; assert in simulation.
- Mispredict:
  - On IN_mispr: REC captures its inputs.
  - CNT <= (IN_misprFetchID - COM + 1) mod 2**FETCH_ID_W, treated as DEPTH when the result is 0 and CNT was DEPTH. Apply a same-cycle commit first.
  - A fetch in the same cycle is dropped.
- Recovery (cycle after IN_mispr):
  - Read checkpoint C at REC.fetchID.
  - HIST_WRITE_0/1: R = C.history advanced through slots with offs < REC.offs, then one bit 0/1 appended.
  - Otherwise: R = C.history advanced through slots with offs <= REC.offs, and HIST_APPEND_1 then appends 1.
  - H <= R, unless a fetch occurs that cycle; that fetch uses R and the normal fetch update applies.
  - A new IN_mispr during recovery overwrites REC; the later mispredict wins.
- Update read:
  - On IN_updValid: OUT_updValid=1 and OUT_updHistory = checkpoint[IN_updFetchID].history one cycle later.
  - A same-cycle write to the same ID returns the old data.
- OUT_stall = (CNT == DEPTH).

## Timing
- Reset values: H=0, CNT=0, COM=0, REC.valid=0, OUT_updValid=0, OUT_updHistory=0, OUT_stall=0, OUT_history=0. RAM is not reset; reading an unwritten entry is undefined.
- Fetch-to-history latency: 1 cycle. Mispredict-to-recovered-history: visible on OUT_history 1 cycle after IN_mispr, and in H after 2 cycles.
- Update read latency: 1 cycle, fully pipelined, one request per cycle.
- Reset asserted mid-recovery clears REC immediately; no recovery completes.
- Fetch-ID and COM arithmetic wrap modulo DEPTH.

## Structure
- Shared package: HistoryAction enum, BHist_t (HIST_LEN), FetchID_t, FetchOff_t, and the checkpoint struct.
- One sub-module, bht_shift: a combinational "advance history through slots up to offset, inclusive/exclusive" function used by both the fetch and recovery paths.
- RAM: the existing RegFile with 2 read ports (recovery, update) and 1 write port.

## Test plan
- Reset, then fetch ID0 with brValid=2'b11, offs {1,4}, taken {0,1} -> next OUT_history = 16'h0001.
- H=16'h00F0, fetch ID3 with taken slot0 at offs 2 and slot1 valid -> H=16'h01E1; slot1 ignored.
- Checkpoint ID3 = 16'h00F0 {offs 2 T, offs 5 NT}; mispr ID3 offs 2 HIST_WRITE_0 -> OUT_history=16'h01E0 next cycle. Same with offs 5 HIST_NONE -> 16'h03C2.
- Fetch 8 IDs with no commits -> OUT_stall=1 after the 8th. One commit -> OUT_stall=0 the next cycle.
- Mispr on ID5 with COM=2 and CNT=8 -> CNT=4. A fetch in the same cycle is not checkpointed.
- IN_updValid ID1 holding 16'hABCD -> OUT_updValid=1, OUT_updHistory=16'hABCD after 1 cycle. Same-cycle write to ID1 -> old value returned.

Source files
------------

// File: rtl/branch_history_tracker_pkg.sv
// Purpose: shared types and default widths for the branch history tracker.
// Latency: n/a (types only).
// Backpressure: n/a.
package branch_history_tracker_pkg;

    localparam int HIST_LEN_C   = 16;
    localparam int FETCH_ID_W_C = 3;
    localparam int MAX_BR_C     = 2;
    localparam int OFFS_W_C     = 3;

    typedef enum logic [1:0] {
        HIST_NONE     = 2'd0,
        HIST_WRITE_0  = 2'd1,
        HIST_WRITE_1  = 2'd2,
        HIST_APPEND_1 = 2'd3
    } HistoryAction;

    typedef logic [HIST_LEN_C-1:0]   BHist_t;
    typedef logic [FETCH_ID_W_C-1:0] FetchID_t;
    typedef logic [OFFS_W_C-1:0]     FetchOff_t;

    // history must stay the first (MSB) field: the update read port
    // returns only the top HIST_LEN bits of an entry.
    typedef struct packed {
        BHist_t                    history;
        logic [MAX_BR_C-1:0]       brValid;
        FetchOff_t [MAX_BR_C-1:0]  brOffs;
        logic [MAX_BR_C-1:0]       brTaken;
    } Checkpoint_t;

    typedef struct packed {
        logic         valid;
        FetchID_t     fetchID;
        FetchOff_t    offs;
        HistoryAction histAct;
    } Recovery_t;

endpackage

// File: rtl/branch_history_tracker_bht_shift.sv
// Purpose: advance a global history through the branch slots of one bundle,
//          optionally limited to offsets below/up to limit_offs_i.
// Latency: combinational. Backpressure: none.
// Ports: hist_i in, br_*_i slot info, limit_*/inclusive_i/stop_on_taken_i control, hist_o out.
module bht_shift
    import branch_history_tracker_pkg::*;
(
    input  logic [HIST_LEN_C-1:0]              hist_i,
    input  logic [MAX_BR_C-1:0]                br_valid_i,
    input  logic [MAX_BR_C-1:0][OFFS_W_C-1:0]  br_offs_i,
    input  logic [MAX_BR_C-1:0]                br_taken_i,
    input  logic                               limit_en_i,
    input  logic [OFFS_W_C-1:0]                limit_offs_i,
    input  logic                               inclusive_i,
    input  logic                               stop_on_taken_i,
    output logic [HIST_LEN_C-1:0]              hist_o
);
    logic [HIST_LEN_C-1:0] acc;
    logic                  stopped;
    logic                  in_range;

    // Slots arrive in ascending offset order, so slot index order is
    // program order. A taken branch ends the bundle on the fetch path;
    // recovery replays every in-range slot exactly as recorded.
    always_comb begin
        acc      = hist_i;
        stopped  = 1'b0;
        in_range = 1'b0;
        for (int i = 0; i < MAX_BR_C; i++) begin
            in_range = !limit_en_i ||
                       (inclusive_i ? (br_offs_i[i] <= limit_offs_i)
                                    : (br_offs_i[i] <  limit_offs_i));
            if (br_valid_i[i] && in_range && !stopped) begin
                acc = {acc[HIST_LEN_C-2:0], br_taken_i[i]};
                if (stop_on_taken_i && br_taken_i[i]) begin
                    stopped = 1'b1;
                end
            end
        end
        hist_o = acc;
    end

endmodule

// File: rtl/branch_history_tracker_regfile.sv
// Purpose: unreset register file, 1 write port, 2 combinational read ports
//          (port 0 full entry, port 1 only the top RD1_W bits of an entry).
// Latency: reads combinational, write visible the cycle after we_i.
// Backpressure: none.
// Ports: clk; we_i/waddr_i/wdata_i write; raddr0_i/rdata0_o, raddr1_i/rdata1_o reads.
module RegFile #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3,
    parameter int RD1_W  = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr0_i,
    output logic [WIDTH-1:0]  rdata0_o,
    input  logic [ADDR_W-1:0] raddr1_i,
    output logic [RD1_W-1:0]  rdata1_o
);
    logic [WIDTH-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i][WIDTH-1 -: RD1_W];

endmodule

// File: rtl/branch_history_tracker.sv
// Purpose: speculative global history with per-fetch-ID checkpoints, one-cycle
//          mispredict recovery and a registered checkpoint read port.
// Latency: fetch->history 1 cycle; mispredict->OUT_history 1 cycle; update read 1 cycle.
// Backpressure: OUT_stall while all DEPTH checkpoints are live.
// Ports: IN_fetch*/IN_br* fetch, OUT_history/OUT_stall, IN_comValid commit,
//        IN_mispr* recovery, IN_upd*/OUT_upd* checkpoint history read.
module branch_history_tracker
    import branch_history_tracker_pkg::*;
#(
    parameter int HIST_LEN   = HIST_LEN_C,
    parameter int FETCH_ID_W = FETCH_ID_W_C,
    parameter int MAX_BR     = MAX_BR_C,
    parameter int OFFS_W     = OFFS_W_C
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           IN_fetchValid,
    input  logic [FETCH_ID_W-1:0]          IN_fetchID,
    input  logic [MAX_BR-1:0]              IN_brValid,
    input  logic [MAX_BR-1:0][OFFS_W-1:0]  IN_brOffs,
    input  logic [MAX_BR-1:0]              IN_brTaken,
    output logic [HIST_LEN-1:0]            OUT_history,
    output logic                           OUT_stall,
    input  logic                           IN_comValid,
    input  logic                           IN_mispr,
    input  logic [FETCH_ID_W-1:0]          IN_misprFetchID,
    input  logic [OFFS_W-1:0]              IN_misprOffs,
    input  logic [1:0]                     IN_misprHistAct,
    input  logic                           IN_updValid,
    input  logic [FETCH_ID_W-1:0]          IN_updFetchID,
    output logic                           OUT_updValid,
    output logic [HIST_LEN-1:0]            OUT_updHistory
);
    localparam int       DEPTH   = 2**FETCH_ID_W;
    localparam int       CNT_W   = FETCH_ID_W + 1;
    localparam int       CK_W    = $bits(Checkpoint_t);
    localparam FetchID_t FID_ONE = FetchID_t'(1);

    BHist_t           h_q, h_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_after_com;
    FetchID_t         com_q, com_d, mispr_diff;
    Recovery_t        rec_q, rec_d;
    logic             upd_vld_q;
    BHist_t           upd_hist_q;

    Checkpoint_t      ck_wr, ck_rec;
    logic [CK_W-1:0]  rf_rdata0;
    BHist_t           rf_rdata1;
    BHist_t           lookup_hist, fetch_hist, rec_adv, rec_hist;
    logic             fetch_do, rec_incl;

    // A mispredict squashes any fetch presented in the same cycle.
    assign fetch_do = IN_fetchValid && !IN_mispr;

    always_comb begin
        ck_wr         = '0;
        ck_wr.history = lookup_hist;
        ck_wr.brValid = IN_brValid;
        ck_wr.brOffs  = IN_brOffs;
        ck_wr.brTaken = IN_brTaken;
    end

    RegFile #(
        .WIDTH  (CK_W),
        .ADDR_W (FETCH_ID_W),
        .RD1_W  (HIST_LEN)
    ) u_ckpt (
        .clk      (clk),
        .we_i     (fetch_do),
        .waddr_i  (IN_fetchID),
        .wdata_i  (ck_wr),
        .raddr0_i (rec_q.fetchID),
        .rdata0_o (rf_rdata0),
        .raddr1_i (IN_updFetchID),
        .rdata1_o (rf_rdata1)
    );

    assign ck_rec = Checkpoint_t'(rf_rdata0);

    // WRITE actions replace the mispredicting branch's own bit, so that
    // slot is excluded from the replay; the other actions keep it.
    assign rec_incl = (rec_q.histAct != HIST_WRITE_0) && (rec_q.histAct != HIST_WRITE_1);

    bht_shift u_rec_shift (
        .hist_i          (ck_rec.history),
        .br_valid_i      (ck_rec.brValid),
        .br_offs_i       (ck_rec.brOffs),
        .br_taken_i      (ck_rec.brTaken),
        .limit_en_i      (1'b1),
        .limit_offs_i    (rec_q.offs),
        .inclusive_i     (rec_incl),
        .stop_on_taken_i (1'b0),
        .hist_o          (rec_adv)
    );

    always_comb begin
        rec_hist = rec_adv;
        case (rec_q.histAct)
            HIST_WRITE_0:                rec_hist = {rec_adv[HIST_LEN-2:0], 1'b0};
            HIST_WRITE_1, HIST_APPEND_1: rec_hist = {rec_adv[HIST_LEN-2:0], 1'b1};
            default:                     rec_hist = rec_adv;
        endcase
    end

    // Recovered history bypasses H so fetch sees it one cycle after the mispredict.
    assign lookup_hist = rec_q.valid ? rec_hist : h_q;

    bht_shift u_fetch_shift (
        .hist_i          (lookup_hist),
        .br_valid_i      (IN_brValid),
        .br_offs_i       (IN_brOffs),
        .br_taken_i      (IN_brTaken),
        .limit_en_i      (1'b0),
        .limit_offs_i    ('0),
        .inclusive_i     (1'b1),
        .stop_on_taken_i (1'b1),
        .hist_o          (fetch_hist)
    );

    always_comb begin
        com_d         = com_q + FetchID_t'(IN_comValid);
        cnt_after_com = cnt_q - CNT_W'(IN_comValid);
        // Live bundles after a mispredict: COM .. misprFetchID inclusive.
        // A zero result is ambiguous between empty and full; it can only
        // mean full if the file was full.
        mispr_diff    = IN_misprFetchID - com_d + FID_ONE;
        cnt_d         = cnt_after_com;
        if (IN_mispr) begin
            if ((mispr_diff == '0) && (cnt_after_com == CNT_W'(DEPTH))) begin
                cnt_d = CNT_W'(DEPTH);
            end else begin
                cnt_d = {1'b0, mispr_diff};
            end
        end else if (fetch_do) begin
            cnt_d = cnt_after_com + CNT_W'(1);
        end

        h_d = h_q;
        if (fetch_do) begin
            h_d = fetch_hist;
        end else if (rec_q.valid) begin
            h_d = rec_hist;
        end

        rec_d       = '0;
        rec_d.valid = IN_mispr;
        if (IN_mispr) begin
            rec_d.fetchID = IN_misprFetchID;
            rec_d.offs    = IN_misprOffs;
            rec_d.histAct = HistoryAction'(IN_misprHistAct);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q        <= '0;
            cnt_q      <= '0;
            com_q      <= '0;
            rec_q      <= '0;
            upd_vld_q  <= 1'b0;
            upd_hist_q <= '0;
        end else begin
            h_q       <= h_d;
            cnt_q     <= cnt_d;
            com_q     <= com_d;
            rec_q     <= rec_d;
            upd_vld_q <= IN_updValid;
            if (IN_updValid) begin
                upd_hist_q <= rf_rdata1;
            end
        end
    end

    assign OUT_history    = lookup_hist;
    assign OUT_stall      = (cnt_q == CNT_W'(DEPTH));
    assign OUT_updValid   = upd_vld_q;
    assign OUT_updHistory = upd_hist_q;

    a_commit_live: assert property (@(posedge clk) disable iff (rst)
        IN_comValid |-> (cnt_q != '0));

endmodule

// File: tb/tb_branch_history_tracker.sv
// Purpose: directed self-checking bench for branch_history_tracker.
// Latency: n/a. Backpressure: n/a.
module tb_branch_history_tracker;
    import branch_history_tracker_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            IN_fetchValid;
    logic [2:0]      IN_fetchID;
    logic [1:0]      IN_brValid;
    logic [1:0][2:0] IN_brOffs;
    logic [1:0]      IN_brTaken;
    logic [15:0]     OUT_history;
    logic            OUT_stall;
    logic            IN_comValid;
    logic            IN_mispr;
    logic [2:0]      IN_misprFetchID;
    logic [2:0]      IN_misprOffs;
    logic [1:0]      IN_misprHistAct;
    logic            IN_updValid;
    logic [2:0]      IN_updFetchID;
    logic            OUT_updValid;
    logic [15:0]     OUT_updHistory;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_history_tracker dut (
        .clk             (clk),
        .rst             (rst),
        .IN_fetchValid   (IN_fetchValid),
        .IN_fetchID      (IN_fetchID),
        .IN_brValid      (IN_brValid),
        .IN_brOffs       (IN_brOffs),
        .IN_brTaken      (IN_brTaken),
        .OUT_history     (OUT_history),
        .OUT_stall       (OUT_stall),
        .IN_comValid     (IN_comValid),
        .IN_mispr        (IN_mispr),
        .IN_misprFetchID (IN_misprFetchID),
        .IN_misprOffs    (IN_misprOffs),
        .IN_misprHistAct (IN_misprHistAct),
        .IN_updValid     (IN_updValid),
        .IN_updFetchID   (IN_updFetchID),
        .OUT_updValid    (OUT_updValid),
        .OUT_updHistory  (OUT_updHistory)
    );

    task automatic idle();
        IN_fetchValid   = 1'b0;
        IN_fetchID      = '0;
        IN_brValid      = '0;
        IN_brOffs       = '0;
        IN_brTaken      = '0;
        IN_comValid     = 1'b0;
        IN_mispr        = 1'b0;
        IN_misprFetchID = '0;
        IN_misprOffs    = '0;
        IN_misprHistAct = '0;
        IN_updValid     = 1'b0;
        IN_updFetchID   = '0;
    endtask

    task automatic fetch(input logic [2:0] id, input logic [1:0] bv,
                         input logic [2:0] o0, input logic [2:0] o1, input logic [1:0] tk);
        IN_fetchValid = 1'b1;
        IN_fetchID    = id;
        IN_brValid    = bv;
        IN_brOffs[0]  = o0;
        IN_brOffs[1]  = o1;
        IN_brTaken    = tk;
    endtask

    task automatic mispr(input logic [2:0] id, input logic [2:0] offs, input logic [1:0] act);
        IN_mispr        = 1'b1;
        IN_misprFetchID = id;
        IN_misprOffs    = offs;
        IN_misprHistAct = act;
    endtask

    task automatic upd(input logic [2:0] id);
        IN_updValid   = 1'b1;
        IN_updFetchID = id;
    endtask

    // One clock with the currently driven inputs; sample #1 after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_history", OUT_history, 16'h0000);
        chk("rst_stall", OUT_stall, 1'b0);
        chk("rst_updValid", OUT_updValid, 1'b0);
        chk("rst_updHistory", OUT_updHistory, 16'h0000);
        rst = 1'b0;

        // two valid slots, first not taken, second taken
        fetch(3'd0, 2'b11, 3'd1, 3'd4, 2'b10); step();
        chk("fetch0_hist", OUT_history, 16'h0001);
        fetch(3'd1, 2'b01, 3'd0, 3'd0, 2'b01); step();
        chk("fetch1_hist", OUT_history, 16'h0003);
        fetch(3'd2, 2'b01, 3'd0, 3'd0, 2'b01); step();
        fetch(3'd3, 2'b01, 3'd0, 3'd0, 2'b01); step();
        chk("fetch3_hist", OUT_history, 16'h000F);
        fetch(3'd4, 2'b11, 3'd1, 3'd4, 2'b00); step();
        chk("fetch4_hist", OUT_history, 16'h003C);
        fetch(3'd5, 2'b11, 3'd1, 3'd4, 2'b00); step();
        chk("fetch5_hist", OUT_history, 16'h00F0);
        fetch(3'd6, 2'b00, 3'd0, 3'd0, 2'b00); step();
        chk("stall_7_live", OUT_stall, 1'b0);
        fetch(3'd7, 2'b00, 3'd0, 3'd0, 2'b00); step();
        chk("stall_8_live", OUT_stall, 1'b1);
        chk("empty_fetch_hist", OUT_history, 16'h00F0);
        IN_comValid = 1'b1; step();
        chk("stall_after_commit", OUT_stall, 1'b0);

        // recycle IDs 0..2 with fetch+commit pairs, history unchanged
        fetch(3'd0, 2'b00, 3'd0, 3'd0, 2'b00); IN_comValid = 1'b1; step();
        fetch(3'd1, 2'b00, 3'd0, 3'd0, 2'b00); IN_comValid = 1'b1; step();
        fetch(3'd2, 2'b00, 3'd0, 3'd0, 2'b00); IN_comValid = 1'b1; step();

        // ID3 from 00F0: slot0 taken at offs 2, slot1 at offs 5 is ignored;
        // update read of ID3 in the same cycle returns the old checkpoint
        fetch(3'd3, 2'b11, 3'd2, 3'd5, 2'b01); IN_comValid = 1'b1; upd(3'd3); step();
        chk("taken_stop_hist", OUT_history, 16'h01E1);
        chk("upd_valid", OUT_updValid, 1'b1);
        chk("upd_same_cycle_old", OUT_updHistory, 16'h0007);

        mispr(3'd3, 3'd2, HIST_WRITE_0); upd(3'd3); step();
        chk("rec_write0_hist", OUT_history, 16'h01E0);
        chk("upd_new_ckpt", OUT_updHistory, 16'h00F0);

        // later mispredict during recovery wins
        mispr(3'd3, 3'd5, HIST_NONE); upd(3'd4); step();
        chk("rec_none_hist", OUT_history, 16'h03C2);
        chk("upd_pipelined", OUT_updHistory, 16'h000F);

        step();
        chk("rec_committed_H", OUT_history, 16'h03C2);
        chk("upd_idle_valid", OUT_updValid, 1'b0);

        mispr(3'd3, 3'd2, HIST_WRITE_1); step();
        chk("rec_write1_hist", OUT_history, 16'h01E1);

        // reset in the middle of recovery clears the bypass at once
        rst = 1'b1;
        #1;
        chk("rst_mid_rec_hist", OUT_history, 16'h0000);
        chk("rst_mid_rec_stall", OUT_stall, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        chk("no_rec_after_rst", OUT_history, 16'h0000);

        // fill all eight IDs
        fetch(3'd0, 2'b01, 3'd0, 3'd0, 2'b01); step();
        for (int i = 1; i < 7; i++) begin
            fetch(3'(i), 2'b00, 3'd0, 3'd0, 2'b00); step();
        end
        fetch(3'd7, 2'b01, 3'd0, 3'd0, 2'b01); step();
        chk("lap1_hist", OUT_history, 16'h0003);
        chk("lap1_stall", OUT_stall, 1'b1);
        IN_comValid = 1'b1; step();
        IN_comValid = 1'b1; step();
        fetch(3'd0, 2'b00, 3'd0, 3'd0, 2'b00); step();
        fetch(3'd1, 2'b00, 3'd0, 3'd0, 2'b00); step();
        chk("full_com2_stall", OUT_stall, 1'b1);

        // COM=2, CNT=8: mispredict on ID5 leaves 4 live; fetch of ID2 dropped
        mispr(3'd5, 3'd0, HIST_WRITE_0); fetch(3'd2, 2'b01, 3'd0, 3'd0, 2'b01); step();
        chk("mispr_rec_hist", OUT_history, 16'h0002);
        chk("mispr_cnt_stall", OUT_stall, 1'b0);

        // fetch during recovery builds on the recovered history
        fetch(3'd6, 2'b01, 3'd0, 3'd0, 2'b01); upd(3'd2); step();
        chk("fetch_on_rec_hist", OUT_history, 16'h0005);
        chk("dropped_fetch_ckpt", OUT_updHistory, 16'h0001);
        fetch(3'd7, 2'b00, 3'd0, 3'd0, 2'b00); upd(3'd6); step();
        chk("fetch_on_rec_ckpt", OUT_updHistory, 16'h0002);
        fetch(3'd0, 2'b00, 3'd0, 3'd0, 2'b00); step();
        chk("cnt7_stall", OUT_stall, 1'b0);
        fetch(3'd1, 2'b00, 3'd0, 3'd0, 2'b00); step();
        chk("cnt8_stall", OUT_stall, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
